ac97_slotgen: RTL and testbench
===============================

# ac97_slotgen

Downlink slot generator for the AC'97 controller. It sits directly upstream of the AC'97 framer and supplies the slot 1–4 contents and valid flags for every outgoing frame. Codec register commands and stereo PCM samples are queued here and released one frame at a time on the framer's `next_frame` pulse. All slot outputs are held stable for the whole frame.

## Interface
Parameters:
- `PCM_DEPTH`, 4, PCM FIFO depth in stereo samples; power of two, ≥2.

Ports:
- `sys_clk` in 1: system clock; the only clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `enable` in 1: global downlink enable.
- `en` out 1: enable to framer.
- `next_frame` in 1: one-cycle pulse from framer at frame start.
- `addr_valid`, `data_valid`, `pcmleft_valid`, `pcmright_valid` out 1 each: slot 1–4 tag bits.
- `addr`, `data`, `pcmleft`, `pcmright` out 20 each: slot 1–4 contents.
- `cmd_stb` in 1: command request.
- `cmd_write` in 1: 1 = register write, 0 = register read.
- `cmd_addr` in 7: codec register index.
- `cmd_wdata` in 16: write data.
- `cmd_ack` out 1: command accepted (pulse).
- `cmd_done` out 1: command frame fully transmitted (pulse).
- `pcm_stb` in 1: sample push request.
- `pcm_left`, `pcm_right` in 16 each: sample pair.
- `pcm_ack` out 1: sample accepted; combinational, `pcm_stb & ~full`.
- `pcm_level` out clog2(PCM_DEPTH)+1: FIFO occupancy.
- `underrun` out 1: pulse when a frame starts with an empty FIFO.

## Operation
- Frame event: `fe = next_frame & en`. All slot outputs change only on the cycle after `fe`.
- `en` is `enable` registered (1-cycle latency). While `en` is low, no `fe` occurs and all state holds.

Command FSM with states IDLE, PENDING, ISSUED:
- IDLE: when `cmd_stb` is high, latch write/addr/wdata, pulse `cmd_ack`, go to PENDING.
  - If `fe` occurs in the same cycle, it is not used by this command.
- PENDING: on `fe`, load the slots as follows, then go to ISSUED.
  - `addr_valid` = 1.
  - `addr` = {~cmd_write, cmd_addr, 12'h000}.
  - `data_valid` = cmd_write.
  - `data` = cmd_write ? {cmd_wdata, 4'h0} : 20'h0.
- ISSUED: on `fe`, pulse `cmd_done`, clear `addr_valid`/`data_valid`/`addr`/`data` to 0, go to IDLE.
  - `cmd_stb` is not accepted in the same cycle as that `fe`.
- `cmd_stb` is ignored (no `cmd_ack`) outside IDLE. The requester holds `cmd_stb` until `cmd_ack`.

PCM FIFO:
- Push when `pcm_stb & ~full`. Full and empty are computed from the level at the start of the cycle.
- On `fe` with FIFO non-empty: pop, set `pcmleft` = {left, 4'h0}, `pcmright` = {right, 4'h0}, both valid = 1.
- On `fe` with FIFO empty: both valid = 0, both data = 0, pulse `underrun`.
- Simultaneous push and pop: the level is unchanged. Pointers wrap modulo `PCM_DEPTH`.
- At full, a push is refused even if a pop happens in the same cycle.

## Timing
- Reset values:
  - `en`, all valid flags, `cmd_ack`, `cmd_done`, `underrun` = 0.
  - All slot data = 0.
  - `pcm_level` = 0, FSM = IDLE.
- Reset mid-operation: a pending or issued command is dropped with no `cmd_done`, and the FIFO is flushed.
- Latencies:
  - `cmd_stb` to `cmd_ack`: 1 cycle, registered.
  - `fe` to slot outputs, `cmd_done`, and `underrun`: 1 cycle.
  - `pcm_level` updates 1 cycle after the push or pop.
- Slot outputs are stable from `fe`+1 until the next `fe`+1. The framer samples the tags ≥2 cycles after `fe` and the slots ≥16 bit-times later.
- A command occupies exactly one frame. Command throughput is at most one command per two frames.

## Structure
- Shared package `ac97_pkg`:
  - Slot width constant `AC97_SLOT_W` = 20.
  - Read/write bit position 19, register-index field [18:12].
  - PCM/data left-justify shift of 4.
  - FSM state enum.
- One sub-module: `ac97_pcm_fifo`, a synchronous FIFO of 32-bit pairs with `PCM_DEPTH`, level, full and empty.
- Command FSM and slot registers stay in the top level.

## Test plan
- Write: `cmd_write`=1, `cmd_addr`=7'h02, `cmd_wdata`=16'h8000, then two `fe` pulses.
  - `cmd_ack` on the next cycle.
  - After 1st `fe`: `addr`=20'h02000, `data`=20'h80000, both valid.
  - After 2nd `fe`: `cmd_done` pulses and the slots clear.
- Read: `cmd_write`=0, `cmd_addr`=7'h7C.
  - After `fe`: `addr`=20'hFC000, `addr_valid`=1, `data_valid`=0, `data`=0.
- PCM: push (16'h1234, 16'hABCD), then `fe`.
  - `pcmleft`=20'h12340, `pcmright`=20'hABCD0, both valid, `pcm_level` goes 1→0.
  - Next `fe`: both valid 0 and `underrun` pulses.
- Full/wrap with `PCM_DEPTH`=4:
  - 5 pushes: the 5th gets `pcm_ack`=0.
  - Push and `fe` in the same cycle at full: the push is refused and the level goes to 3.
  - 8 frames of alternating push/pop: data order preserved across pointer wrap.
- Boundary:
  - `cmd_stb` on the same cycle as `fe` in IDLE: the command appears only after the following `fe`.
  - `cmd_stb` in PENDING: no `cmd_ack`.
  - `sys_rst` in ISSUED: no `cmd_done`, all outputs 0.
  - `enable` low: `en` goes 0 the next cycle and `fe` pulses are ignored.

Source files
------------

// File: rtl/ac97_pkg.sv
// ac97_pkg: definitions shared by the AC'97 downlink slot generator.
//   - AC97_SLOT_W      : width of one AC'97 slot (20 bits)
//   - AC97_RW_BIT      : read/write flag position inside the slot 1 address word
//   - AC97_IDX_HI/LO   : codec register index field inside the slot 1 address word
//   - AC97_JUST_SHIFT  : left-justify shift for 16-bit values in a 20-bit slot
//   - cmd_state_t      : command FSM states
package ac97_pkg;

  localparam int AC97_SLOT_W     = 20;
  localparam int AC97_RW_BIT     = 19;
  localparam int AC97_IDX_HI     = 18;
  localparam int AC97_IDX_LO     = 12;
  localparam int AC97_JUST_SHIFT = 4;

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'd0,
    CMD_PENDING = 2'd1,
    CMD_ISSUED  = 2'd2
  } cmd_state_t;

  // 16-bit value placed in the top bits of a 20-bit slot.
  function automatic logic [AC97_SLOT_W-1:0] ac97_left_justify(input logic [15:0] val);
    return {val, {AC97_JUST_SHIFT{1'b0}}};
  endfunction

  // Slot 1 address word: bit 19 set for a read, register index in [18:12].
  function automatic logic [AC97_SLOT_W-1:0] ac97_cmd_slot(input logic       write,
                                                           input logic [6:0] idx);
    logic [AC97_SLOT_W-1:0] slot;
    slot                          = '0;
    slot[AC97_RW_BIT]             = ~write;
    slot[AC97_IDX_HI:AC97_IDX_LO] = idx;
    return slot;
  endfunction

endpackage

// File: rtl/ac97_pcm_fifo.sv
// ac97_pcm_fifo: synchronous FIFO holding stereo sample pairs.
//   clk, srst        : clock, synchronous active-high reset (flushes the FIFO)
//   i_push, i_wdata  : push request and data; ignored while full
//   i_pop            : pop request; ignored while empty
//   o_rdata          : head-of-queue data (valid while not empty)
//   o_level          : occupancy, 0..DEPTH
//   o_full, o_empty  : decoded from the level at the start of the cycle
module ac97_pcm_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_level == (AW+1)'(DEPTH));
  assign w_empty   = (r_level == '0);
  // A push at full is refused even if a pop frees a slot in the same cycle.
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~w_empty;

  // The consumer registers the head on the pop cycle, so the head is read
  // combinationally; the storage is tiny and maps to distributed RAM.
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = w_full;
  assign o_empty = w_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH (a power of two).
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ac97_slotgen.sv
// ac97_slotgen: AC'97 downlink slot 1-4 generator feeding the framer.
//   sys_clk, sys_rst            : clock, synchronous active-high reset
//   enable / en                 : global enable in / registered enable to framer
//   next_frame                  : frame-start pulse from the framer
//   addr*/data*/pcmleft*/pcmright* : slot 1-4 contents and tag bits, held per frame
//   cmd_*                       : codec register command request/ack/done
//   pcm_*                       : stereo sample push interface and FIFO level
//   underrun                    : pulse when a frame starts with no sample queued
module ac97_slotgen
  import ac97_pkg::*;
#(
  parameter int PCM_DEPTH = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       enable,
  output logic                       en,
  input  logic                       next_frame,
  output logic                       addr_valid,
  output logic                       data_valid,
  output logic                       pcmleft_valid,
  output logic                       pcmright_valid,
  output logic [AC97_SLOT_W-1:0]     addr,
  output logic [AC97_SLOT_W-1:0]     data,
  output logic [AC97_SLOT_W-1:0]     pcmleft,
  output logic [AC97_SLOT_W-1:0]     pcmright,
  input  logic                       cmd_stb,
  input  logic                       cmd_write,
  input  logic [6:0]                 cmd_addr,
  input  logic [15:0]                cmd_wdata,
  output logic                       cmd_ack,
  output logic                       cmd_done,
  input  logic                       pcm_stb,
  input  logic [15:0]                pcm_left,
  input  logic [15:0]                pcm_right,
  output logic                       pcm_ack,
  output logic [$clog2(PCM_DEPTH):0] pcm_level,
  output logic                       underrun
);

  cmd_state_t r_state;
  logic       r_en;
  logic       r_cmd_write;
  logic [6:0] r_cmd_addr;
  logic [15:0] r_cmd_wdata;
  logic       r_cmd_ack;
  logic       r_cmd_done;
  logic       r_underrun;
  logic       r_addr_valid;
  logic       r_data_valid;
  logic       r_pcm_valid;
  logic [AC97_SLOT_W-1:0] r_addr;
  logic [AC97_SLOT_W-1:0] r_data;
  logic [AC97_SLOT_W-1:0] r_pcmleft;
  logic [AC97_SLOT_W-1:0] r_pcmright;

  logic        w_fe;
  logic [31:0] w_head;
  logic        w_full;
  logic        w_empty;

  // Frames only advance while the registered enable is high.
  assign w_fe = next_frame & r_en;

  ac97_pcm_fifo #(
    .DEPTH (PCM_DEPTH),
    .WIDTH (32)
  ) u_pcm_fifo (
    .clk     (sys_clk),
    .srst    (sys_rst),
    .i_push  (pcm_stb),
    .i_wdata ({pcm_left, pcm_right}),
    .i_pop   (w_fe),
    .o_rdata (w_head),
    .o_level (pcm_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign pcm_ack = pcm_stb & ~w_full;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= CMD_IDLE;
      r_en         <= 1'b0;
      r_cmd_write  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
      r_cmd_ack    <= 1'b0;
      r_cmd_done   <= 1'b0;
      r_underrun   <= 1'b0;
      r_addr_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_pcm_valid  <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_pcmleft    <= '0;
      r_pcmright   <= '0;
    end else begin
      r_en       <= enable;
      r_cmd_ack  <= 1'b0;
      r_cmd_done <= 1'b0;
      r_underrun <= 1'b0;

      case (r_state)
        // A frame event in this same cycle is deliberately not used: the
        // command waits for the next full frame.
        CMD_IDLE: begin
          if (cmd_stb) begin
            r_cmd_write <= cmd_write;
            r_cmd_addr  <= cmd_addr;
            r_cmd_wdata <= cmd_wdata;
            r_cmd_ack   <= 1'b1;
            r_state     <= CMD_PENDING;
          end
        end
        CMD_PENDING: begin
          if (w_fe) begin
            r_addr_valid <= 1'b1;
            r_addr       <= ac97_cmd_slot(r_cmd_write, r_cmd_addr);
            r_data_valid <= r_cmd_write;
            r_data       <= r_cmd_write ? ac97_left_justify(r_cmd_wdata) : '0;
            r_state      <= CMD_ISSUED;
          end
        end
        CMD_ISSUED: begin
          if (w_fe) begin
            r_cmd_done   <= 1'b1;
            r_addr_valid <= 1'b0;
            r_data_valid <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_state      <= CMD_IDLE;
          end
        end
        default: r_state <= CMD_IDLE;
      endcase

      if (w_fe) begin
        if (!w_empty) begin
          r_pcm_valid <= 1'b1;
          r_pcmleft   <= ac97_left_justify(w_head[31:16]);
          r_pcmright  <= ac97_left_justify(w_head[15:0]);
        end else begin
          r_pcm_valid <= 1'b0;
          r_pcmleft   <= '0;
          r_pcmright  <= '0;
          r_underrun  <= 1'b1;
        end
      end
    end
  end

  assign en             = r_en;
  assign cmd_ack        = r_cmd_ack;
  assign cmd_done       = r_cmd_done;
  assign underrun       = r_underrun;
  assign addr_valid     = r_addr_valid;
  assign data_valid     = r_data_valid;
  assign pcmleft_valid  = r_pcm_valid;
  assign pcmright_valid = r_pcm_valid;
  assign addr           = r_addr;
  assign data           = r_data;
  assign pcmleft        = r_pcmleft;
  assign pcmright       = r_pcmright;

endmodule

// File: tb/tb_ac97_slotgen.sv
// tb_ac97_slotgen: directed and randomized bench for ac97_slotgen with a
// queue-based reference model compared on every falling clock edge.
module tb_ac97_slotgen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_rst, enable, en, next_frame;
  logic        addr_valid, data_valid, pcmleft_valid, pcmright_valid;
  logic [19:0] addr, data, pcmleft, pcmright;
  logic        cmd_stb, cmd_write, cmd_ack, cmd_done;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        pcm_stb, pcm_ack, underrun;
  logic [15:0] pcm_left, pcm_right;
  logic [2:0]  pcm_level;

  ac97_slotgen #(.PCM_DEPTH(DEPTH)) dut (
    .sys_clk        (clk),
    .sys_rst        (sys_rst),
    .enable         (enable),
    .en             (en),
    .next_frame     (next_frame),
    .addr_valid     (addr_valid),
    .data_valid     (data_valid),
    .pcmleft_valid  (pcmleft_valid),
    .pcmright_valid (pcmright_valid),
    .addr           (addr),
    .data           (data),
    .pcmleft        (pcmleft),
    .pcmright       (pcmright),
    .cmd_stb        (cmd_stb),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_ack        (cmd_ack),
    .cmd_done       (cmd_done),
    .pcm_stb        (pcm_stb),
    .pcm_left       (pcm_left),
    .pcm_right      (pcm_right),
    .pcm_ack        (pcm_ack),
    .pcm_level      (pcm_level),
    .underrun       (underrun)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      if (n_fails <= 40)
        $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Expected outputs for the current cycle; stepped on each falling edge
  // from the inputs that the next rising edge will sample.
  bit          m_valid = 1'b0;
  logic        m_en, m_av, m_dv, m_pv, m_ack, m_done, m_under;
  logic [19:0] m_addr, m_data, m_pl, m_pr;
  int          m_frames_left;   // 0: no command; 2: waiting to go on air; 1: on air
  logic        m_cw;
  logic [6:0]  m_ca;
  logic [15:0] m_cd;
  logic [31:0] m_q[$];
  logic [31:0] m_s;
  bit          m_fe, m_full;

  task automatic model_clear();
    m_en = 0; m_av = 0; m_dv = 0; m_pv = 0; m_ack = 0; m_done = 0; m_under = 0;
    m_addr = 0; m_data = 0; m_pl = 0; m_pr = 0; m_frames_left = 0;
    m_q.delete();
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("en",         32'(en),             32'(m_en));
      chk("addr_valid", 32'(addr_valid),     32'(m_av));
      chk("data_valid", 32'(data_valid),     32'(m_dv));
      chk("pcml_valid", 32'(pcmleft_valid),  32'(m_pv));
      chk("pcmr_valid", 32'(pcmright_valid), 32'(m_pv));
      chk("addr",       32'(addr),           32'(m_addr));
      chk("data",       32'(data),           32'(m_data));
      chk("pcmleft",    32'(pcmleft),        32'(m_pl));
      chk("pcmright",   32'(pcmright),       32'(m_pr));
      chk("cmd_ack",    32'(cmd_ack),        32'(m_ack));
      chk("cmd_done",   32'(cmd_done),       32'(m_done));
      chk("underrun",   32'(underrun),       32'(m_under));
      chk("pcm_level",  32'(pcm_level),      32'(m_q.size()));
      chk("pcm_ack",    32'(pcm_ack),        32'(pcm_stb && (m_q.size() != DEPTH)));
    end
    if (sys_rst) begin
      model_clear();
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_fe   = next_frame && m_en;
      m_full = (m_q.size() == DEPTH);
      m_en   = enable;
      m_ack  = 0; m_done = 0; m_under = 0;
      if (m_frames_left == 0) begin
        if (cmd_stb) begin
          m_cw = cmd_write; m_ca = cmd_addr; m_cd = cmd_wdata;
          m_ack = 1; m_frames_left = 2;
          $display("cmd %s idx=%02h wdata=%04h accepted at %0t",
                   cmd_write ? "write" : "read ", cmd_addr, cmd_wdata, $time);
        end
      end else if (m_fe) begin
        if (m_frames_left == 2) begin
          m_av   = 1;
          m_addr = (m_cw ? 20'h0 : 20'h80000) + (20'(m_ca) * 20'h1000);
          m_dv   = m_cw;
          m_data = m_cw ? 20'(m_cd) * 20'd16 : 20'h0;
        end else begin
          m_done = 1; m_av = 0; m_dv = 0; m_addr = 0; m_data = 0;
        end
        m_frames_left--;
      end
      if (m_fe) begin
        if (m_q.size() > 0) begin
          m_s  = m_q.pop_front();
          m_pv = 1;
          m_pl = 20'(m_s[31:16]) * 20'd16;
          m_pr = 20'(m_s[15:0]) * 20'd16;
        end else begin
          m_pv = 0; m_pl = 0; m_pr = 0; m_under = 1;
        end
      end
      if (pcm_stb && !m_full) m_q.push_back({pcm_left, pcm_right});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    sys_rst = 1; enable = 0; next_frame = 0;
    cmd_stb = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    pcm_stb = 0; pcm_left = 0; pcm_right = 0;
    tick(); tick();
    chk("rst_en",    32'(en),         32'h0);
    chk("rst_av",    32'(addr_valid), 32'h0);
    chk("rst_addr",  32'(addr),       32'h0);
    chk("rst_level", 32'(pcm_level),  32'h0);
    chk("rst_ack",   32'(cmd_ack),    32'h0);
    sys_rst = 0; enable = 1;
    tick();
    chk("en_on", 32'(en), 32'h1);

    // register write
    cmd_stb = 1; cmd_write = 1; cmd_addr = 7'h02; cmd_wdata = 16'h8000;
    tick();
    chk("wr_ack", 32'(cmd_ack), 32'h1);
    cmd_stb = 0;
    tick();
    chk("wr_ack_pulse", 32'(cmd_ack), 32'h0);
    frame();
    chk("wr_addr", 32'(addr), 32'h02000);
    chk("wr_data", 32'(data), 32'h80000);
    chk("wr_av",   32'(addr_valid), 32'h1);
    chk("wr_dv",   32'(data_valid), 32'h1);
    chk("wr_under", 32'(underrun), 32'h1);
    tick(); tick();
    chk("wr_hold", 32'(addr), 32'h02000);
    frame();
    chk("wr_done", 32'(cmd_done), 32'h1);
    chk("wr_clr_addr", 32'(addr), 32'h0);
    chk("wr_clr_av",   32'(addr_valid), 32'h0);
    chk("wr_clr_data", 32'(data), 32'h0);
    tick();
    chk("wr_done_pulse", 32'(cmd_done), 32'h0);

    // register read
    cmd_stb = 1; cmd_write = 0; cmd_addr = 7'h7C; cmd_wdata = 16'hFFFF;
    tick();
    chk("rd_ack", 32'(cmd_ack), 32'h1);
    cmd_stb = 0;
    frame();
    chk("rd_addr", 32'(addr), 32'hFC000);
    chk("rd_av",   32'(addr_valid), 32'h1);
    chk("rd_dv",   32'(data_valid), 32'h0);
    chk("rd_data", 32'(data), 32'h0);
    frame();
    chk("rd_done", 32'(cmd_done), 32'h1);

    // single PCM sample then underrun
    pcm_stb = 1; pcm_left = 16'h1234; pcm_right = 16'hABCD;
    #1 chk("pcm_ack1", 32'(pcm_ack), 32'h1);
    tick();
    pcm_stb = 0;
    chk("pcm_lvl1", 32'(pcm_level), 32'h1);
    frame();
    chk("pcm_left",  32'(pcmleft),  32'h12340);
    chk("pcm_right", 32'(pcmright), 32'hABCD0);
    chk("pcm_lv",    32'(pcmleft_valid),  32'h1);
    chk("pcm_rv",    32'(pcmright_valid), 32'h1);
    chk("pcm_lvl0",  32'(pcm_level), 32'h0);
    frame();
    chk("und_lv",  32'(pcmleft_valid), 32'h0);
    chk("und_rv",  32'(pcmright_valid), 32'h0);
    chk("und_pls", 32'(underrun), 32'h1);

    // fill to full, refused 5th push, push+pop at full
    for (int i = 0; i < 4; i++) begin
      pcm_stb = 1; pcm_left = 16'h1000 + 16'(i); pcm_right = 16'h2000 + 16'(i);
      tick();
    end
    chk("full_lvl", 32'(pcm_level), 32'h4);
    pcm_left = 16'h1004; pcm_right = 16'h2004;
    #1 chk("full_ack", 32'(pcm_ack), 32'h0);
    tick();
    chk("full_lvl2", 32'(pcm_level), 32'h4);
    next_frame = 1;
    tick();
    next_frame = 0; pcm_stb = 0;
    chk("full_pop_lvl", 32'(pcm_level), 32'h3);
    chk("full_pop_l",   32'(pcmleft),   32'h10000);
    for (int i = 1; i < 4; i++) begin
      frame();
      chk("drain_l", 32'(pcmleft), 32'h10000 + 32'(i) * 32'h10);
    end
    chk("drain_lvl", 32'(pcm_level), 32'h0);

    // alternating push/pop across pointer wrap
    for (int i = 0; i < 8; i++) begin
      pcm_stb = 1; pcm_left = 16'(i * 16'h0111); pcm_right = ~pcm_left;
      tick();
      pcm_stb = 0;
      frame();
      chk("alt_r", 32'(pcmright), 32'((~(i * 32'h0111)) & 32'hFFFF) * 32'd16);
    end

    // command request coinciding with a frame in IDLE
    cmd_stb = 1; cmd_write = 1; cmd_addr = 7'h15; cmd_wdata = 16'h5A5A; next_frame = 1;
    tick();
    next_frame = 0; cmd_stb = 0;
    chk("idlefe_ack", 32'(cmd_ack), 32'h1);
    chk("idlefe_av",  32'(addr_valid), 32'h0);
    cmd_stb = 1; cmd_addr = 7'h33;
    tick();
    chk("pend_noack", 32'(cmd_ack), 32'h0);
    cmd_stb = 0;
    frame();
    chk("idlefe_addr", 32'(addr), 32'h15000);
    chk("idlefe_data", 32'(data), 32'h5A5A0);

    // reset while the command is on air
    sys_rst = 1;
    tick();
    sys_rst = 0;
    chk("rst_iss_av",   32'(addr_valid), 32'h0);
    chk("rst_iss_addr", 32'(addr), 32'h0);
    chk("rst_iss_en",   32'(en), 32'h0);
    tick();
    frame();
    chk("rst_iss_done", 32'(cmd_done), 32'h0);
    chk("rst_iss_und",  32'(underrun), 32'h1);

    // enable low suppresses frames
    pcm_stb = 1; pcm_left = 16'hCAFE; pcm_right = 16'hBEEF;
    tick();
    pcm_stb = 0; enable = 0;
    tick();
    chk("dis_en", 32'(en), 32'h0);
    frame();
    chk("dis_lv",  32'(pcmleft_valid), 32'h0);
    chk("dis_lvl", 32'(pcm_level), 32'h1);
    chk("dis_und", 32'(underrun), 32'h0);
    enable = 1;
    tick();
    frame();
    chk("reen_l", 32'(pcmleft), 32'hCAFE0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sys_rst    = ($urandom_range(0, 599) == 0);
      enable     = ($urandom_range(0, 19) != 0);
      next_frame = ($urandom_range(0, 7) == 0);
      if (cmd_stb && cmd_ack) begin
        cmd_stb = 0;
      end else if (!cmd_stb && $urandom_range(0, 3) == 0) begin
        cmd_stb   = 1;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 7'($urandom);
        cmd_wdata = 16'($urandom);
      end
      pcm_stb   = 1'($urandom_range(0, 1));
      pcm_left  = 16'($urandom);
      pcm_right = 16'($urandom);
      tick();
    end
    sys_rst = 0; next_frame = 0; cmd_stb = 0; pcm_stb = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
